// File: rtl/mdio_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master_if
// Description : Command/response handshake plus the split MDC/MDIO pin
//               bundle of the clause-22 management master.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_t;
    logic        mdio_i;

    // Environment view: issues commands, observes responses and pins, and
    // returns the resolved MDIO line.
    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mdc, mdio_o, mdio_t,
        output mdio_i
    );

    // Management master view.
    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output mdc, mdio_o, mdio_t,
        input  mdio_i
    );
endinterface
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : IEEE 802.3 clause-22 MDIO master. One read or write frame per
//               accepted command, MDC divided from clk, split MDIO pin pair.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int MDC_DIV     = 50,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mdio_master_if.slave bus
);

    localparam int                 c_DIV_W    = $clog2(MDC_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(MDC_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(MDC_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [c_DIV_W-1:0]   r_div_q,       w_div_d;
    logic [5:0]           r_bit_q,       w_bit_d;
    logic                 r_write_q,     w_write_d;
    logic [31:0]          r_tx_q,        w_tx_d;
    logic [15:0]          r_rx_q,        w_rx_d;
    logic                 r_ta_err_q,    w_ta_err_d;
    logic                 r_cmd_ready_q, w_cmd_ready_d;
    logic                 r_rsp_valid_q, w_rsp_valid_d;
    logic [15:0]          r_rsp_rdata_q, w_rsp_rdata_d;
    logic                 r_rsp_err_q,   w_rsp_err_d;
    logic                 r_mdc_q,       w_mdc_d;
    logic                 r_mdio_o_q,    w_mdio_o_d;
    logic                 r_mdio_t_q,    w_mdio_t_d;

    // Frame sequencing, read capture and next values of the registered pins.
    always_comb begin
        w_state_d     = r_state_q;
        w_div_d       = r_div_q;
        w_bit_d       = r_bit_q;
        w_write_d     = r_write_q;
        w_tx_d        = r_tx_q;
        w_rx_d        = r_rx_q;
        w_ta_err_d    = r_ta_err_q;
        w_rsp_valid_d = 1'b0;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;

        unique case (r_state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_write_d  = bus.cmd_write;
                    // ST, OP, PHYAD, REGAD, write TA, DATA shifted out MSB first
                    w_tx_d     = {2'b01, (bus.cmd_write ? 2'b01 : 2'b10),
                                  bus.cmd_phy_addr, bus.cmd_reg_addr, 2'b10,
                                  bus.cmd_wdata};
                    w_div_d    = '0;
                    w_ta_err_d = 1'b0;
                    if (PREAMBLE_EN) begin
                        w_state_d = S_PRE;
                        w_bit_d   = 6'd31;
                    end else begin
                        w_state_d = S_HDR;
                        w_bit_d   = 6'd13;
                    end
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                // First cycle of MDC high: PHY data is stable here
                if (r_div_q == c_DIV_HALF) begin
                    if (r_state_q == S_TA && r_bit_q == 6'd0 && !r_write_q) begin
                        w_ta_err_d = bus.mdio_i;
                    end
                    if (r_state_q == S_DATA) begin
                        w_rx_d = {r_rx_q[14:0], bus.mdio_i};
                    end
                end
                if (r_div_q == c_DIV_LAST) begin
                    w_div_d = '0;
                    if (r_state_q != S_PRE) begin
                        w_tx_d = {r_tx_q[30:0], 1'b0};
                    end
                    if (r_bit_q == 6'd0) begin
                        case (r_state_q)
                            S_PRE: begin
                                w_state_d = S_HDR;
                                w_bit_d   = 6'd13;
                            end
                            S_HDR: begin
                                w_state_d = S_TA;
                                w_bit_d   = 6'd1;
                            end
                            S_TA: begin
                                w_state_d = S_DATA;
                                w_bit_d   = 6'd15;
                            end
                            default: begin
                                w_state_d     = S_DONE;
                                w_rsp_valid_d = 1'b1;
                                w_rsp_rdata_d = r_write_q ? 16'h0000 : r_rx_q;
                                w_rsp_err_d   = r_write_q ? 1'b0 : r_ta_err_q;
                            end
                        endcase
                    end else begin
                        w_bit_d = r_bit_q - 6'd1;
                    end
                end else begin
                    w_div_d = r_div_q + c_DIV_W'(1);
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Pin values are derived from the next state so they are registered
        w_cmd_ready_d = (w_state_d == S_IDLE);
        w_mdio_o_d    = 1'b1;
        w_mdio_t_d    = 1'b1;
        w_mdc_d       = 1'b0;
        unique case (w_state_d)
            S_PRE: begin
                w_mdio_t_d = 1'b0;
            end
            S_HDR: begin
                w_mdio_t_d = 1'b0;
                w_mdio_o_d = w_tx_d[31];
            end
            S_TA, S_DATA: begin
                if (w_write_d) begin
                    w_mdio_t_d = 1'b0;
                    w_mdio_o_d = w_tx_d[31];
                end
            end
            default: begin
            end
        endcase
        if (w_state_d inside {S_PRE, S_HDR, S_TA, S_DATA}) begin
            w_mdc_d = (w_div_d >= c_DIV_HALF);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_div_q       <= '0;
            r_bit_q       <= 6'd0;
            r_write_q     <= 1'b0;
            r_tx_q        <= 32'h0;
            r_rx_q        <= 16'h0;
            r_ta_err_q    <= 1'b0;
            r_cmd_ready_q <= 1'b1;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= 16'h0;
            r_rsp_err_q   <= 1'b0;
            r_mdc_q       <= 1'b0;
            r_mdio_o_q    <= 1'b1;
            r_mdio_t_q    <= 1'b1;
        end else begin
            r_state_q     <= w_state_d;
            r_div_q       <= w_div_d;
            r_bit_q       <= w_bit_d;
            r_write_q     <= w_write_d;
            r_tx_q        <= w_tx_d;
            r_rx_q        <= w_rx_d;
            r_ta_err_q    <= w_ta_err_d;
            r_cmd_ready_q <= w_cmd_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_mdc_q       <= w_mdc_d;
            r_mdio_o_q    <= w_mdio_o_d;
            r_mdio_t_q    <= w_mdio_t_d;
        end
    end

    assign bus.cmd_ready = r_cmd_ready_q;
    assign bus.rsp_valid = r_rsp_valid_q;
    assign bus.rsp_rdata = r_rsp_rdata_q;
    assign bus.rsp_err   = r_rsp_err_q;
    assign bus.mdc       = r_mdc_q;
    assign bus.mdio_o    = r_mdio_o_q;
    assign bus.mdio_t    = r_mdio_t_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_master
// Description : Self-checking bench for mdio_master. Two instances: fast
//               divider with preamble, and MDC_DIV=50 without preamble. A bus
//               model decodes bits on MDC rising edges and a PHY model answers
//               reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdio_master_if ifa ();
    mdio_master_if ifb ();

    mdio_master #(.MDC_DIV(4),  .PREAMBLE_EN(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mdio_master #(.MDC_DIV(50), .PREAMBLE_EN(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Stimulus shared by both instances; sel picks the one under test
    logic        sel;
    logic        cmd_valid;
    logic        cmd_write;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic        phy_drv;
    logic        phy_bit;

    assign ifa.cmd_valid    = cmd_valid & ~sel;
    assign ifb.cmd_valid    = cmd_valid &  sel;
    assign ifa.cmd_write    = cmd_write;
    assign ifb.cmd_write    = cmd_write;
    assign ifa.cmd_phy_addr = pa;
    assign ifb.cmd_phy_addr = pa;
    assign ifa.cmd_reg_addr = ra;
    assign ifb.cmd_reg_addr = ra;
    assign ifa.cmd_wdata    = wd;
    assign ifb.cmd_wdata    = wd;

    // Resolved line: master drive when enabled, else PHY drive, else pull-up
    assign ifa.mdio_i = ifa.mdio_t ? ((phy_drv && !sel) ? phy_bit : 1'b1) : ifa.mdio_o;
    assign ifb.mdio_i = ifb.mdio_t ? ((phy_drv &&  sel) ? phy_bit : 1'b1) : ifb.mdio_o;

    logic        w_ready, w_valid, w_err, w_mdc, w_o, w_t, w_line;
    logic [15:0] w_rdata;
    assign w_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
    assign w_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign w_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign w_err   = sel ? ifb.rsp_err   : ifa.rsp_err;
    assign w_mdc   = sel ? ifb.mdc       : ifa.mdc;
    assign w_o     = sel ? ifb.mdio_o    : ifa.mdio_o;
    assign w_t     = sel ? ifb.mdio_t    : ifa.mdio_t;
    assign w_line  = sel ? ifb.mdio_i    : ifa.mdio_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete frame on the selected instance, checked against the
    // clause-22 frame built from the command fields and the PHY behaviour.
    task automatic run_frame(input bit s, input bit wr, input logic [4:0] pa_i,
                             input logic [4:0] ra_i, input logic [15:0] wd_i,
                             input bit present, input logic [15:0] pd, input bit hold);
        int          div, p, n, last, edges, vcnt, vcyc, wait_cnt;
        logic [63:0] cap, capt, exp_bits, exp_t;
        logic [31:0] frame;
        logic [15:0] exp_rd, got_rd;
        logic        exp_err, got_err, prev, bad_rel;
        div   = s ? 50 : 4;
        p     = s ? 0 : 32;
        n     = p + 32;
        last  = n * div;
        cap   = '0;
        capt  = '0;
        edges = 0;
        vcnt  = 0;
        vcyc  = -1;
        prev  = 1'b0;
        bad_rel = 1'b0;
        got_rd  = '0;
        got_err = 1'b0;
        sel     = s;
        phy_drv = 1'b0;
        phy_bit = 1'b1;

        @(negedge clk);
        wait_cnt = 0;
        while (!w_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("ready_before_cmd", 64'(w_ready), 64'd1);
        if (!w_ready) return;

        cmd_valid = 1'b1;
        cmd_write = wr;
        pa        = pa_i;
        ra        = ra_i;
        wd        = wd_i;
        if (!hold) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            pa        = 5'($urandom);
            ra        = 5'($urandom);
            wd        = 16'($urandom);
        end

        for (int cyc = 1; cyc <= last + 2; cyc++) begin
            @(negedge clk);
            if (w_mdc && !prev) begin
                cap  = {cap[62:0],  w_line};
                capt = {capt[62:0], w_t};
                edges++;
            end
            // PHY presents its next bit while MDC is low
            if (!w_mdc) begin
                phy_drv = 1'b0;
                phy_bit = 1'b1;
                if (!wr && present && edges >= p + 15 && edges <= p + 31) begin
                    phy_drv = 1'b1;
                    if (edges == p + 15) phy_bit = 1'b0;
                    else                 phy_bit = pd[p + 31 - edges];
                end
            end
            if (w_t && !w_o) bad_rel = 1'b1;
            if (w_valid) begin
                vcnt++;
                vcyc    = cyc;
                got_rd  = w_rdata;
                got_err = w_err;
            end
            if (cyc == last + 1)
                chk("done_cycle_pins", 64'({w_valid, w_ready, w_mdc, w_t, w_o}), 64'h13);
            if (cyc == last + 2)
                chk("ready_after_done", 64'({w_valid, w_ready, w_mdc, w_t}), 64'h5);
            prev = w_mdc;
        end
        phy_drv = 1'b0;

        if (wr) begin
            exp_rd  = 16'h0000;
            exp_err = 1'b0;
            frame   = {2'b01, 2'b01, pa_i, ra_i, 2'b10, wd_i};
            exp_t   = 64'h0;
        end else begin
            exp_rd  = present ? pd : 16'hFFFF;
            exp_err = !present;
            frame   = {2'b01, 2'b10, pa_i, ra_i, 1'b1, !present, exp_rd};
            exp_t   = 64'h3FFFF;
        end
        exp_bits = (p == 32) ? {32'hFFFF_FFFF, frame} : {32'h0, frame};

        chk("frame_bits",     cap,             exp_bits);
        chk("mdc_edges",      64'(edges),      64'(n));
        chk("mdio_t_pattern", capt,            exp_t);
        chk("released_high",  64'(bad_rel),    64'd0);
        chk("rsp_count",      64'(vcnt),       64'd1);
        chk("rsp_cycle",      64'(vcyc),       64'(last + 1));
        chk("rsp_rdata",      64'(got_rd),     64'(exp_rd));
        chk("rsp_err",        64'(got_err),    64'(exp_err));
        chk("rdata_held",     64'({w_rdata, w_err}), 64'({exp_rd, exp_err}));

        if (hold) begin
            @(negedge clk);
            chk("b2b_accepted", 64'(w_ready), 64'd0);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        int vcount;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        pa        = '0;
        ra        = '0;
        wd        = '0;
        phy_drv   = 1'b0;
        phy_bit   = 1'b1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: pins parked, ready high, no response
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_a", 64'({ifa.cmd_ready, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err,
                               ifa.mdc, ifa.mdio_o, ifa.mdio_t}), 64'h200003);
            chk("idle_b", 64'({ifb.cmd_ready, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err,
                               ifb.mdc, ifb.mdio_o, ifb.mdio_t}), 64'h200003);
        end

        // Directed frames on the fast instance
        run_frame(1'b0, 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 1'b0);
        run_frame(1'b0, 1'b0, 5'h01, 5'h01, 16'h0000, 1'b1, 16'h796D, 1'b0);
        run_frame(1'b0, 1'b0, 5'h01, 5'h01, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Randomized frames
        for (int k = 0; k < 4; k++) begin
            run_frame(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                      16'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom), 1'b0);
        end

        // Reset during the header of a write
        sel = 1'b0;
        @(negedge clk);
        chk("ready_before_abort", 64'(w_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        pa        = 5'h03;
        ra        = 5'h04;
        wd        = 16'hA5A5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (134) @(negedge clk);
        chk("hdr_driving", 64'(w_t), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_pins", 64'({w_ready, w_valid, w_rdata, w_err, w_mdc, w_o, w_t}),
            64'h200003);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w_valid) vcount++;
        end
        chk("abort_no_rsp", 64'(vcount), 64'd0);
        run_frame(1'b0, 1'b0, 5'h02, 5'h11, 16'h0000, 1'b1, 16'($urandom), 1'b0);

        // No preamble, MDC_DIV=50, command held for back-to-back accept
        run_frame(1'b1, 1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 16'($urandom), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
